fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit_record.sv | 35 +++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM encoding and small helpers for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int ADDR_BUS_WIDTH = 32;
  localparam int INST_BUS_WIDTH = 32;
  localparam int GHR_WIDTH      = 10;

  // Fetch FSM: REQ issues a request, WAIT holds for the response,
  // OUT presents the instruction, DISCARD swallows a response made stale by a flush.
  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_OUT     = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  // Per-fetch metadata captured when the memory accepts a request.
  typedef struct packed {
    logic [ADDR_BUS_WIDTH-1:0] pc;
    logic                      taken;
    logic [GHR_WIDTH-1:0]      pht;
  } fetch_meta_t;

  // Sequential successor; wraps modulo 2^ADDR_BUS_WIDTH, low bits untouched.
  function automatic logic [ADDR_BUS_WIDTH-1:0] next_seq_pc(input logic [ADDR_BUS_WIDTH-1:0] pc);
    return pc + ADDR_BUS_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit and memory.
//
// Handshake: a request is accepted in any cycle where rom_en && rom_ready are
// both high; rom_addr must be stable while rom_en is high. The fetch unit keeps
// at most one request outstanding. rom_rvalid pulses for one cycle with
// rom_rdata, no earlier than the cycle after acceptance; there is no response
// back-pressure, so the fetch unit must absorb every response it receives.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                      rom_en;
  logic [ADDR_BUS_WIDTH-1:0] rom_addr;
  logic                      rom_ready;
  logic                      rom_rvalid;
  logic [INST_BUS_WIDTH-1:0] rom_rdata;

  modport master (
    output rom_en,
    output rom_addr,
    input  rom_ready,
    input  rom_rvalid,
    input  rom_rdata
  );

  modport slave (
    input  rom_en,
    input  rom_addr,
    output rom_ready,
    output rom_rvalid,
    output rom_rdata
  );
endinterface

// File: rtl/fetch_unit_record.sv
// Fetch record: holds pc/taken/pht of the accepted request and the returned
// instruction word. Metadata and instruction load independently because they
// arrive in different cycles; clear wins over load.
module fetch_record
  import fetch_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_load_meta,
  input  fetch_meta_t               i_meta,
  input  logic                      i_load_inst,
  input  logic [INST_BUS_WIDTH-1:0] i_inst,
  output fetch_meta_t               o_meta,
  output logic [INST_BUS_WIDTH-1:0] o_inst
);

  fetch_meta_t               r_meta;
  logic [INST_BUS_WIDTH-1:0] r_inst;

  // Load, hold or clear the record fields.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_meta <= '0;
      r_inst <= '0;
    end else begin
      if (i_load_meta) r_meta <= i_meta;
      if (i_load_inst) r_inst <= i_inst;
    end
  end

  assign o_meta = r_meta;
  assign o_inst = r_inst;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding instruction-memory request, branch
// prediction applied at request acceptance, flush redirect with stale-response
// discard, and a stallable output slot toward the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_BUS_WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [ADDR_BUS_WIDTH-1:0] flush_pc,
  input  logic                      stall,
  input  logic                      pred_taken,
  input  logic [ADDR_BUS_WIDTH-1:0] pred_target,
  input  logic [GHR_WIDTH-1:0]      pred_pht_index,
  fetch_unit_if.master              bus,
  output logic                      valid_out,
  output logic [ADDR_BUS_WIDTH-1:0] pc_out,
  output logic [INST_BUS_WIDTH-1:0] inst_out,
  output logic                      is_branch_taken_out,
  output logic [GHR_WIDTH-1:0]      pht_index_out,
  output fetch_state_e              dbg_state
);

  fetch_state_e              r_state;
  logic [ADDR_BUS_WIDTH-1:0] r_pc;
  logic                      r_valid_out;

  logic                      w_accept;
  logic                      w_load_meta;
  logic                      w_load_inst;
  logic                      w_clear;
  fetch_meta_t               w_meta_in;
  fetch_meta_t               w_meta;
  logic [INST_BUS_WIDTH-1:0] w_inst;

  assign w_accept = (r_state == ST_REQ) && bus.rom_ready;

  // Record is only written by fetches that survive; a flush or a consumed
  // output empties it.
  assign w_load_meta = w_accept && !flush;
  assign w_load_inst = (r_state == ST_WAIT) && bus.rom_rvalid && !flush;
  assign w_clear     = flush || ((r_state == ST_OUT) && !stall);

  assign w_meta_in.pc    = r_pc;
  assign w_meta_in.taken = pred_taken;
  assign w_meta_in.pht   = pred_pht_index;

  // Fetch FSM with pc and output-valid registers; flush outranks everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_REQ;
      r_pc        <= RESET_PC;
      r_valid_out <= 1'b0;
    end else if (flush) begin
      r_pc        <= flush_pc;
      r_valid_out <= 1'b0;
      case (r_state)
        ST_REQ:     r_state <= bus.rom_ready  ? ST_DISCARD : ST_REQ;
        ST_WAIT:    r_state <= bus.rom_rvalid ? ST_REQ     : ST_DISCARD;
        ST_OUT:     r_state <= ST_REQ;
        ST_DISCARD: r_state <= bus.rom_rvalid ? ST_REQ     : ST_DISCARD;
        default:    r_state <= ST_REQ;
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (bus.rom_ready) begin
            r_pc    <= pred_taken ? pred_target : next_seq_pc(r_pc);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.rom_rvalid) begin
            r_state     <= ST_OUT;
            r_valid_out <= 1'b1;
          end
        end
        ST_OUT: begin
          if (!stall) begin
            r_state     <= ST_REQ;
            r_valid_out <= 1'b0;
          end
        end
        ST_DISCARD: begin
          if (bus.rom_rvalid) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  fetch_record u_record (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_load_meta (w_load_meta),
    .i_meta      (w_meta_in),
    .i_load_inst (w_load_inst),
    .i_inst      (bus.rom_rdata),
    .o_meta      (w_meta),
    .o_inst      (w_inst)
  );

  assign bus.rom_en   = (r_state == ST_REQ);
  assign bus.rom_addr = r_pc;

  // Metadata is already loaded while waiting, so gate the outputs to zero
  // (nop) until the instruction is actually presented.
  assign valid_out           = r_valid_out;
  assign pc_out              = r_valid_out ? w_meta.pc    : '0;
  assign inst_out            = r_valid_out ? w_inst       : '0;
  assign is_branch_taken_out = r_valid_out ? w_meta.taken : 1'b0;
  assign pht_index_out       = r_valid_out ? w_meta.pht   : '0;
  assign dbg_state           = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed cycle table, a hand-written mid-output
// reset sequence, and a randomized run against a transaction-level model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [GHR_WIDTH-1:0] TBL_PHT = 10'h2A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                      flush;
  logic [ADDR_BUS_WIDTH-1:0] flush_pc;
  logic                      stall;
  logic                      pred_taken;
  logic [ADDR_BUS_WIDTH-1:0] pred_target;
  logic [GHR_WIDTH-1:0]      pred_pht_index;
  logic                      valid_out;
  logic [ADDR_BUS_WIDTH-1:0] pc_out;
  logic [INST_BUS_WIDTH-1:0] inst_out;
  logic                      is_branch_taken_out;
  logic [GHR_WIDTH-1:0]      pht_index_out;
  fetch_state_e              dbg_state;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .flush_pc            (flush_pc),
    .stall               (stall),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .pred_pht_index      (pred_pht_index),
    .bus                 (bus),
    .valid_out           (valid_out),
    .pc_out              (pc_out),
    .inst_out            (inst_out),
    .is_branch_taken_out (is_branch_taken_out),
    .pht_index_out       (pht_index_out),
    .dbg_state           (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush = 1'b0; flush_pc = '0; stall = 1'b0;
    pred_taken = 1'b0; pred_target = '0; pred_pht_index = '0;
    bus.rom_ready = 1'b0; bus.rom_rvalid = 1'b0; bus.rom_rdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_en", 32'(bus.rom_en), 32'd1);
    check("rst_rom_addr", bus.rom_addr, RESET_PC);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_inst", inst_out, 32'd0);
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        e_en;  logic [31:0] e_addr; logic e_v;
    logic [31:0] e_pc;  logic [31:0] e_inst; logic e_tk;
    logic        fl;    logic [31:0] fpc;    logic st;
    logic        pt;    logic [31:0] ptgt;
    logic        rdy;   logic        rv;     logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [31:0] addr, input logic v,
                              input logic [31:0] pc, input logic [31:0] inst, input logic tk,
                              input logic fl, input logic [31:0] fpc, input logic st,
                              input logic pt, input logic [31:0] ptgt,
                              input logic rdy, input logic rv, input logic [31:0] rd);
    vec_t r;
    r.e_en = en; r.e_addr = addr; r.e_v = v; r.e_pc = pc; r.e_inst = inst; r.e_tk = tk;
    r.fl = fl; r.fpc = fpc; r.st = st; r.pt = pt; r.ptgt = ptgt;
    r.rdy = rdy; r.rv = rv; r.rd = rd;
    return r;
  endfunction

  vec_t tbl[25];

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [31:0]          pc;
    logic                 tk;
    logic [GHR_WIDTH-1:0] pht;
    logic [31:0]          inst;
    bit                   drop;
  } m_rec_t;

  logic [31:0] m_pc;
  m_rec_t      m_pend[$];   // requests accepted by memory, awaiting data
  m_rec_t      m_out;       // instruction sitting in the output slot
  bit          m_out_v;
  logic [63:0] exp_q[$];    // {pc, inst} of instructions handed downstream

  function automatic bit m_en();
    return (m_pend.size() == 0) && !m_out_v;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC;
    m_pend.delete();
    m_out_v = 1'b0;
    m_out = '{pc: '0, tk: 1'b0, pht: '0, inst: '0, drop: 1'b0};
    exp_q.delete();
  endtask

  task automatic model_step();
    m_rec_t r;
    bit     busy;
    bit     req;
    busy = (m_pend.size() != 0);
    req  = m_en() && bus.rom_ready;
    if (flush) begin
      m_pc    = flush_pc;
      m_out_v = 1'b0;
      if (busy) begin
        if (bus.rom_rvalid) r = m_pend.pop_front();
        else m_pend[0].drop = 1'b1;
      end else if (req) begin
        m_pend.push_back('{pc: '0, tk: 1'b0, pht: '0, inst: '0, drop: 1'b1});
      end
    end else if (req) begin
      m_pend.push_back('{pc: m_pc, tk: pred_taken, pht: pred_pht_index, inst: '0, drop: 1'b0});
      m_pc = pred_taken ? pred_target : m_pc + 32'd4;
    end else if (busy && bus.rom_rvalid) begin
      r = m_pend.pop_front();
      if (!r.drop) begin
        m_out      = r;
        m_out.inst = bus.rom_rdata;
        m_out_v    = 1'b1;
      end
    end else if (m_out_v && !stall) begin
      exp_q.push_back({m_out.pc, m_out.inst});
      m_out_v = 1'b0;
    end
  endtask

  task automatic model_compare();
    check("rnd_rom_en", 32'(bus.rom_en), 32'(m_en()));
    check("rnd_rom_addr", bus.rom_addr, m_pc);
    check("rnd_valid", 32'(valid_out), 32'(m_out_v));
    check("rnd_pc_out", pc_out, m_out_v ? m_out.pc : 32'd0);
    check("rnd_inst_out", inst_out, m_out_v ? m_out.inst : 32'd0);
    check("rnd_taken_out", 32'(is_branch_taken_out), 32'(m_out_v ? m_out.tk : 1'b0));
    check("rnd_pht_out", 32'(pht_index_out), 32'(m_out_v ? m_out.pht : '0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] e;
    bit          mem_busy;
    int          mem_cnt;

    tbl[0]  = mk(1, 32'hBFC0_0000, 0, 0, 0, 0,  0, 0, 0,  0, 0,  1, 0, 0);
    tbl[1]  = mk(0, 32'hBFC0_0004, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 32'h2402_0001);
    tbl[2]  = mk(0, 32'hBFC0_0004, 1, 32'hBFC0_0000, 32'h2402_0001, 0,  0, 0, 0,  0, 0,  0, 0, 0);
    tbl[3]  = mk(1, 32'hBFC0_0004, 0, 0, 0, 0,  0, 0, 0,  1, 32'hBFC0_0100,  1, 0, 0);
    tbl[4]  = mk(0, 32'hBFC0_0100, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
    tbl[5]  = mk(0, 32'hBFC0_0100, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 32'h1111_1111);
    tbl[6]  = mk(0, 32'hBFC0_0100, 1, 32'hBFC0_0004, 32'h1111_1111, 1,  0, 0, 1,  0, 0,  0, 0, 0);
    tbl[7]  = mk(0, 32'hBFC0_0100, 1, 32'hBFC0_0004, 32'h1111_1111, 1,  0, 0, 1,  0, 0,  0, 0, 0);
    tbl[8]  = mk(0, 32'hBFC0_0100, 1, 32'hBFC0_0004, 32'h1111_1111, 1,  0, 0, 1,  1, 32'h1234_5678,  1, 0, 0);
    tbl[9]  = mk(0, 32'hBFC0_0100, 1, 32'hBFC0_0004, 32'h1111_1111, 1,  0, 0, 0,  0, 0,  0, 0, 0);
    tbl[10] = mk(1, 32'hBFC0_0100, 0, 0, 0, 0,  0, 0, 0,  1, 32'hAAAA_0000,  0, 0, 0);
    tbl[11] = mk(1, 32'hBFC0_0100, 0, 0, 0, 0,  0, 0, 0,  0, 0,  1, 0, 0);
    tbl[12] = mk(0, 32'hBFC0_0104, 0, 0, 0, 0,  1, 32'hBFC0_0380, 0,  0, 0,  0, 0, 0);
    tbl[13] = mk(0, 32'hBFC0_0380, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
    tbl[14] = mk(0, 32'hBFC0_0380, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 32'hDEAD_BEEF);
    tbl[15] = mk(1, 32'hBFC0_0380, 0, 0, 0, 0,  0, 0, 0,  0, 0,  1, 0, 0);
    tbl[16] = mk(0, 32'hBFC0_0384, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 32'h2222_2222);
    tbl[17] = mk(0, 32'hBFC0_0384, 1, 32'hBFC0_0380, 32'h2222_2222, 0,  1, 32'hBFC0_0500, 1,  0, 0,  0, 0, 0);
    tbl[18] = mk(1, 32'hBFC0_0500, 0, 0, 0, 0,  1, 32'hFFFF_FFFC, 0,  0, 0,  0, 0, 0);
    tbl[19] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0,  0, 0, 0,  0, 0,  1, 0, 0);
    tbl[20] = mk(0, 32'h0000_0000, 0, 0, 0, 0,  1, 32'hBFC0_0600, 0,  0, 0,  0, 1, 32'h3333_3333);
    tbl[21] = mk(1, 32'hBFC0_0600, 0, 0, 0, 0,  1, 32'hBFC0_0700, 0,  0, 0,  1, 0, 0);
    tbl[22] = mk(0, 32'hBFC0_0700, 0, 0, 0, 0,  1, 32'hBFC0_0800, 0,  0, 0,  0, 0, 0);
    tbl[23] = mk(0, 32'hBFC0_0800, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 32'h4444_4444);
    tbl[24] = mk(1, 32'hBFC0_0800, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);

    do_reset();

    // Directed table: check outputs at cycle start, then drive that cycle's inputs.
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      check($sformatf("vec%0d_rom_en", i), 32'(bus.rom_en), 32'(tbl[i].e_en));
      check($sformatf("vec%0d_rom_addr", i), bus.rom_addr, tbl[i].e_addr);
      check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(tbl[i].e_v));
      check($sformatf("vec%0d_pc_out", i), pc_out, tbl[i].e_pc);
      check($sformatf("vec%0d_inst_out", i), inst_out, tbl[i].e_inst);
      check($sformatf("vec%0d_taken_out", i), 32'(is_branch_taken_out), 32'(tbl[i].e_tk));
      check($sformatf("vec%0d_pht_out", i), 32'(pht_index_out), tbl[i].e_v ? 32'(TBL_PHT) : 32'd0);
      flush = tbl[i].fl;        flush_pc = tbl[i].fpc;   stall = tbl[i].st;
      pred_taken = tbl[i].pt;   pred_target = tbl[i].ptgt; pred_pht_index = TBL_PHT;
      bus.rom_ready = tbl[i].rdy; bus.rom_rvalid = tbl[i].rv; bus.rom_rdata = tbl[i].rd;
    end

    // Hand sequence: synchronous reset while a stalled instruction is presented.
    @(posedge clk); #1;
    drive_idle();
    bus.rom_ready = 1'b1;
    @(posedge clk); #1;
    bus.rom_ready = 1'b0; bus.rom_rvalid = 1'b1; bus.rom_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.rom_rvalid = 1'b0;
    check("hs_valid_before_rst", 32'(valid_out), 32'd1);
    check("hs_pc_before_rst", pc_out, 32'hBFC0_0800);
    check("hs_inst_before_rst", inst_out, 32'h5555_AAAA);
    stall = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0;
    check("hs_valid_after_rst", 32'(valid_out), 32'd0);
    check("hs_inst_after_rst", inst_out, 32'd0);
    check("hs_rom_en_after_rst", 32'(bus.rom_en), 32'd1);
    check("hs_rom_addr_after_rst", bus.rom_addr, RESET_PC);

    // Randomized run against the transaction-level model.
    do_reset();
    model_reset();
    mem_busy = 1'b0;
    mem_cnt  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      model_compare();
      rst            = (cyc % 700 == 699);
      flush          = ($urandom_range(0, 9) == 0);
      flush_pc       = $urandom;
      stall          = ($urandom_range(0, 2) == 0);
      pred_taken     = ($urandom_range(0, 3) == 0);
      pred_target    = $urandom;
      pred_pht_index = GHR_WIDTH'($urandom);
      bus.rom_ready  = ($urandom_range(0, 2) != 0);
      bus.rom_rvalid = mem_busy && (mem_cnt == 0);
      bus.rom_rdata  = $urandom;
      if (rst) begin
        mem_busy = 1'b0;
        model_reset();
      end else begin
        if (bus.rom_rvalid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (bus.rom_en && bus.rom_ready && !mem_busy) begin
          mem_busy = 1'b1;
          mem_cnt  = $urandom_range(0, 3);
        end
        model_step();
        // Scoreboard: an instruction is handed downstream when presented and not stalled or flushed.
        if (valid_out && !stall && !flush) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual pc=%h inst=%h required=no instruction", pc_out, inst_out);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", pc_out, e[63:32]);
            check("sb_inst", inst_out, e[31:0]);
          end
        end
      end
    end
    check("sb_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
